// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   state_e     : arbiter FSM encoding (ST_RUN = 1'b0, ST_HALT = 1'b1)
//   DEF_ADDR_W  : default RAM word-address width
//   DEF_DATA_W  : default RAM data width
package dmem_arb_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Ports:
//   clk        : clock
//   rst        : synchronous active-high reset (count -> 0)
//   clear_i    : clear to zero on the next edge (wins over inc_i)
//   inc_i      : increment on the next edge, holding at LIMIT
//   count_o    : current count
//   at_limit_o : count_o == LIMIT
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] LIMIT_C = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: the default assignment first means every path drives count_d,
        // so no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT_C)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o    = count_q;
    assign at_limit_o = (count_q == LIMIT_C);

endmodule : sat_counter

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter between the pipeline memory stage and a
// debug/boot-loader port. The pipeline normally has priority; a starvation
// counter forces a debug grant after STARVE_LIMIT denied cycles, and halt mode
// freezes the pipeline so the debug port can burst-load the RAM.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pipe_req_i/we_i/addr_i/wdata_i : pipeline access request
//   pipe_rdata_o             : RAM read data, combinational pass-through
//   pipe_stall_o             : pipeline must hold memory stage and earlier
//   dbg_req_i/we_i/addr_i/wdata_i  : debug access request (held until grant)
//   dbg_halt_i               : request halt mode
//   dbg_gnt_o                : debug access performed this cycle
//   dbg_rvalid_o, dbg_rdata_o: registered debug read result
//   halted_o                 : arbiter is in HALT
//   ram_we_o/addr_o/wdata_o  : RAM command
//   ram_rdata_i              : RAM combinational read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_req_i,
    input  logic              pipe_we_i,
    input  logic [ADDR_W-1:0] pipe_addr_i,
    input  logic [DATA_W-1:0] pipe_wdata_i,
    output logic [DATA_W-1:0] pipe_rdata_o,
    output logic              pipe_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    input  logic              dbg_halt_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              halted_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e            state_q, state_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              starve_at_limit;
    logic [CNT_W-1:0]  starve_cnt;
    logic              in_halt;
    logic              gnt;

    // Counts consecutive cycles a debug request has been refused; any cycle
    // without a pending request, or with a grant, restarts the count.
    sat_counter #(
        .WIDTH (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (~dbg_req_i | gnt),
        .inc_i      (1'b1),
        .count_o    (starve_cnt),
        .at_limit_o (starve_at_limit)
    );

    // Grant, stall and RAM mux. The grant uses the current state only, so a
    // halt request arriving with a debug request takes effect a cycle later.
    always_comb begin
        in_halt      = (state_q == ST_HALT);
        gnt          = dbg_req_i & (in_halt | ~pipe_req_i | starve_at_limit);
        pipe_stall_o = in_halt | (gnt & pipe_req_i);

        ram_we_o     = pipe_req_i & pipe_we_i & ~pipe_stall_o;
        ram_addr_o   = pipe_addr_i;
        ram_wdata_o  = pipe_wdata_i;
        if (gnt) begin
            ram_we_o    = dbg_we_i;
            ram_addr_o  = dbg_addr_i;
            ram_wdata_o = dbg_wdata_i;
        end

        // Both RUN->HALT and HALT->RUN follow dbg_halt_i directly.
        state_d  = dbg_halt_i ? ST_HALT : ST_RUN;

        rvalid_d = gnt & ~dbg_we_i;
        rdata_d  = rvalid_d ? ram_rdata_i : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign pipe_rdata_o = ram_rdata_i;
    assign dbg_gnt_o    = gnt;
    assign dbg_rvalid_o = rvalid_q;
    assign dbg_rdata_o  = rdata_q;
    assign halted_o     = (state_q == ST_HALT);

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural single-port RAM
// (combinational read, write on the rising edge).
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_req, pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wdata, pipe_rdata;
    logic              pipe_stall;
    logic              dbg_req, dbg_we, dbg_halt;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              dbg_gnt, dbg_rvalid, halted;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_req_i   (pipe_req),
        .pipe_we_i    (pipe_we),
        .pipe_addr_i  (pipe_addr),
        .pipe_wdata_i (pipe_wdata),
        .pipe_rdata_o (pipe_rdata),
        .pipe_stall_o (pipe_stall),
        .dbg_req_i    (dbg_req),
        .dbg_we_i     (dbg_we),
        .dbg_addr_i   (dbg_addr),
        .dbg_wdata_i  (dbg_wdata),
        .dbg_halt_i   (dbg_halt),
        .dbg_gnt_o    (dbg_gnt),
        .dbg_rvalid_o (dbg_rvalid),
        .dbg_rdata_o  (dbg_rdata),
        .halted_o     (halted),
        .ram_we_o     (ram_we),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_addr];

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then return at the falling edge so new inputs
    // are applied well away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pipe(input logic req, input logic we,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        pipe_req   = req;
        pipe_we    = we;
        pipe_addr  = addr;
        pipe_wdata = data;
    endtask

    task automatic set_dbg(input logic req, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        dbg_req   = req;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = data;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        rst      = 1'b1;
        dbg_halt = 1'b0;
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_rdata",  dbg_rdata, 32'h0);
        check("rst_gnt",    32'(dbg_gnt), 32'd0);
        check("rst_stall",  32'(pipe_stall), 32'd0);

        // Debug write then read of 0x10 with the pipeline idle
        set_dbg(1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
        #1;
        check("dw_gnt",   32'(dbg_gnt), 32'd1);
        check("dw_we",    32'(ram_we), 32'd1);
        check("dw_addr",  32'(ram_addr), 32'h10);
        check("dw_wdata", ram_wdata, 32'hDEADBEEF);
        check("dw_stall", 32'(pipe_stall), 32'd0);
        tick();
        set_dbg(1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        check("dr_gnt",    32'(dbg_gnt), 32'd1);
        check("dr_we",     32'(ram_we), 32'd0);
        check("dr_novalid", 32'(dbg_rvalid), 32'd0);
        tick();
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        check("dr_rvalid", 32'(dbg_rvalid), 32'd1);
        check("dr_rdata",  dbg_rdata, 32'hDEADBEEF);
        tick();
        #1;
        check("dr_rvalid_drop", 32'(dbg_rvalid), 32'd0);
        check("dr_rdata_hold",  dbg_rdata, 32'hDEADBEEF);

        // Starvation: pipeline busy every cycle, debug forced on the 5th
        set_pipe(1'b1, 1'b1, 8'h30, 32'h11);
        set_dbg(1'b1, 1'b1, 8'h31, 32'h55);
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("starve_cnt_%0d", c), 32'(dut.u_starve.count_o), 32'(c));
            check($sformatf("starve_gnt_%0d", c), 32'(dbg_gnt), 32'd0);
            check($sformatf("starve_stall_%0d", c), 32'(pipe_stall), 32'd0);
            check($sformatf("starve_pwe_%0d", c), 32'(ram_we), 32'd1);
            tick();
        end
        #1;
        check("force_gnt",   32'(dbg_gnt), 32'd1);
        check("force_stall", 32'(pipe_stall), 32'd1);
        check("force_addr",  32'(ram_addr), 32'h31);
        check("force_wdata", ram_wdata, 32'h55);
        tick();
        #1;
        check("post_force_cnt",   32'(dut.u_starve.count_o), 32'd0);
        check("post_force_gnt",   32'(dbg_gnt), 32'd0);
        check("post_force_stall", 32'(pipe_stall), 32'd0);
        tick();
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        // Simultaneous requests with starve count 0: pipeline store wins
        set_pipe(1'b1, 1'b1, 8'h05, 32'h1234);
        set_dbg(1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        check("pw_gnt",   32'(dbg_gnt), 32'd0);
        check("pw_stall", 32'(pipe_stall), 32'd0);
        check("pw_we",    32'(ram_we), 32'd1);
        check("pw_addr",  32'(ram_addr), 32'h05);
        check("pw_wdata", ram_wdata, 32'h1234);
        tick();
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        check("pw_cnt", 32'(dut.u_starve.count_o), 32'd1);
        tick();

        // Halt: same-cycle halt + debug request follows RUN rules
        set_pipe(1'b1, 1'b1, 8'h20, 32'hA5A5);
        set_dbg(1'b1, 1'b1, 8'h40, 32'h0);
        dbg_halt = 1'b1;
        #1;
        check("h0_halted", 32'(halted), 32'd0);
        check("h0_gnt",    32'(dbg_gnt), 32'd0);
        check("h0_stall",  32'(pipe_stall), 32'd0);
        check("h0_pwe",    32'(ram_we), 32'd1);
        tick();
        set_pipe(1'b1, 1'b1, 8'h20, 32'hB6B6);
        for (int i = 0; i < 8; i++) begin
            set_dbg(1'b1, 1'b1, 8'(8'h40 + i), 32'(i * 32'h111));
            #1;
            check($sformatf("hb_halted_%0d", i), 32'(halted), 32'd1);
            check($sformatf("hb_stall_%0d", i),  32'(pipe_stall), 32'd1);
            check($sformatf("hb_gnt_%0d", i),    32'(dbg_gnt), 32'd1);
            check($sformatf("hb_addr_%0d", i),   32'(ram_addr), 32'(8'h40 + i));
            tick();
        end
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        dbg_halt = 1'b0;
        #1;
        check("hx_stall", 32'(pipe_stall), 32'd1);
        check("hx_we",    32'(ram_we), 32'd0);
        tick();
        #1;
        check("run_halted", 32'(halted), 32'd0);
        check("run_stall",  32'(pipe_stall), 32'd0);
        check("run_we",     32'(ram_we), 32'd1);
        check("run_wdata",  ram_wdata, 32'hB6B6);
        tick();
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);

        // Debug write then same-cycle-visible pipeline load
        set_dbg(1'b1, 1'b1, 8'h10, 32'hCAFEF00D);
        tick();
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        set_pipe(1'b1, 1'b0, 8'h10, 32'h0);
        #1;
        check("pl_rdata", pipe_rdata, 32'hCAFEF00D);
        check("pl_we",    32'(ram_we), 32'd0);
        tick();
        set_pipe(1'b1, 1'b0, 8'h20, 32'h0);
        #1;
        check("pl_halt_store", pipe_rdata, 32'hB6B6);
        tick();
        set_pipe(1'b1, 1'b0, 8'h05, 32'h0);
        #1;
        check("pl_store05", pipe_rdata, 32'h1234);
        tick();
        set_pipe(1'b1, 1'b0, 8'h31, 32'h0);
        #1;
        check("pl_forced", pipe_rdata, 32'h55);
        tick();
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);

        // Reset in the middle of HALT with a debug read pending
        dbg_halt = 1'b1;
        tick();
        set_dbg(1'b1, 1'b0, 8'h45, 32'h0);
        tick();
        #1;
        check("pre_rst_rdata", dbg_rdata, 32'h555);
        set_pipe(1'b1, 1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_halted", 32'(halted), 32'd0);
        check("mid_rst_gnt",    32'(dbg_gnt), 32'd0);
        check("mid_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("mid_rst_rdata",  dbg_rdata, 32'h0);
        set_pipe(1'b0, 1'b0, 8'h00, 32'h0);
        #1;
        check("mid_rst_gnt_idle", 32'(dbg_gnt), 32'd1);
        dbg_halt = 1'b0;
        set_dbg(1'b0, 1'b0, 8'h00, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmem_arbiter
